// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM state
// encodings, instruction opcode constants and datapath control codes.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_NOP   = 6'b010101;

  // ALU B-operand source select
  typedef enum logic [1:0] {
    ASB_REG  = 2'b00,
    ASB_FOUR = 2'b01,
    ASB_IMM  = 2'b10
  } alu_src_b_e;

  // ALU operation class
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_e;

endpackage

// File: rtl/mcu_opcode_class.sv
// Combinational opcode classifier for the multi-cycle control unit.
// Inputs : opcode, funct  - instruction fields (live or latched copy)
// Outputs: is_rtype, is_load, is_store, is_branch, is_nop,
//          no_wb - instruction finishes without a register writeback
module mcu_opcode_class
  import multicycle_control_unit_pkg::*;
#(
  parameter logic [5:0] JR_FUNCT = 6'b001000
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_rtype,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_nop,
  output logic       no_wb
);

  always_comb begin
    is_rtype  = (opcode == OP_RTYPE);
    is_load   = (opcode == OP_LW);
    is_store  = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_nop    = (opcode == OP_NOP);
    no_wb     = is_store || is_branch || is_nop || (is_rtype && (funct == JR_FUNCT));
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: sequences fetch, decode, execute, memory
// and writeback, one state per clock, and drives the datapath controls.
// Optional feature macro: MEM_TIMEOUT_EN (memory wait timeout + mem_err).
// Inputs : clk, rst (async, active high), opcode, funct, mem_ready
// Outputs: pc_write, ir_write, reg_read, reg_write, reg_dst, mem_read,
//          mem_write, mem_to_reg, alu_src_b[1:0], alu_op[1:0], branch,
//          branch_ne, mem_err (sticky timeout flag), state_o[2:0]
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4,
  parameter logic [5:0]  JR_FUNCT    = 6'b001000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_read,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       branch_ne,
  output logic       mem_err,
  output logic [2:0] state_o
);

  // An undersized wait counter shows up as this named scope in the hierarchy.
  if ((1 << CNT_W) <= MEM_TIMEOUT) begin : g_cnt_w_too_small
  end

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;

  logic [5:0] cls_op, cls_funct;
  logic       is_rtype, is_load, is_store, is_branch, is_nop, no_wb;

  alu_src_b_e asb;
  alu_op_e    aop;

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Abort on the clock at which the count would reach MEM_TIMEOUT, so the
  // forced FETCH lands exactly MEM_TIMEOUT waiting cycles after entry.
  localparam logic [CNT_W-1:0] ABORT_AT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             waiting, abort;

  assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign abort   = waiting && (cnt_q == ABORT_AT);
`endif

  // DECODE classifies the live IR fields; every later state sees the latch.
  always_comb begin
    cls_op    = (state_q == ST_DECODE) ? opcode : op_q;
    cls_funct = (state_q == ST_DECODE) ? funct  : funct_q;
  end

  mcu_opcode_class #(
    .JR_FUNCT (JR_FUNCT)
  ) u_opcode_class (
    .opcode    (cls_op),
    .funct     (cls_funct),
    .is_rtype  (is_rtype),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_nop    (is_nop),
    .no_wb     (no_wb)
  );

  // Next-state and latch logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = opcode;
        funct_d = funct;
        if (is_branch)   state_d = ST_BRANCH;
        else if (is_nop) state_d = ST_FETCH;
        else             state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_load || is_store) state_d = ST_MEM;
        else if (no_wb)          state_d = ST_FETCH;
        else                     state_d = ST_WB;
      end
      ST_MEM: if (mem_ready) state_d = is_load ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    if (abort) state_d = ST_FETCH;
`endif
  end

`ifdef MEM_TIMEOUT_EN
  // FETCH->FETCH on abort is not a state change, so abort clears explicitly.
  always_comb begin
    mem_err_d = mem_err_q || abort;
    if ((state_d != state_q) || abort) cnt_d = '0;
    else if (waiting && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    else cnt_d = cnt_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      funct_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
`endif
    end
  end

  // Moore output decode
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_read   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    asb        = ASB_REG;
    aop        = ALU_ADD;
    unique case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        asb      = ASB_FOUR;
        // IR load and PC+4 commit only with the completing access
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_DECODE: reg_read = !is_nop;
      ST_EXEC: begin
        if (is_rtype) begin
          asb = ASB_REG;
          aop = ALU_FUNCT;
        end else if (is_load || is_store) begin
          asb = ASB_IMM;
          aop = ALU_ADD;
        end else begin
          asb = ASB_IMM;
          aop = ALU_IMM;
        end
      end
      ST_MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_load;
      end
      ST_BRANCH: begin
        aop       = ALU_SUB;
        branch    = (op_q == OP_BEQ);
        branch_ne = (op_q == OP_BNE);
      end
      default: ;
    endcase
  end

  assign alu_src_b = asb;
  assign alu_op    = aop;
  assign state_o   = state_q;

`ifdef MEM_TIMEOUT_EN
  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_read, reg_write, reg_dst;
  logic       mem_read, mem_write, mem_to_reg;
  logic [1:0] alu_src_b, alu_op;
  logic       branch, branch_ne, mem_err;
  logic [2:0] state_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  multicycle_control_unit #(
    .MEM_TIMEOUT (15),
    .CNT_W       (4),
    .JR_FUNCT    (6'b001000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_read   (reg_read),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .branch     (branch),
    .branch_ne  (branch_ne),
    .mem_err    (mem_err),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcw,irw,rr,rw,rd,mr,mw,m2r,asb[1:0],aop[1:0],br,bne,err,state[2:0]}
  logic [17:0] obs;
  assign obs = {pc_write, ir_write, reg_read, reg_write, reg_dst, mem_read,
                mem_write, mem_to_reg, alu_src_b, alu_op, branch, branch_ne,
                mem_err, state_o};

  function automatic logic [17:0] ev(input logic pcw, input logic irw,
      input logic rr, input logic rw, input logic rd, input logic mr,
      input logic mw, input logic m2r, input logic [1:0] asb,
      input logic [1:0] aop, input logic br, input logic bne,
      input logic err, input logic [2:0] st);
    return {pcw, irw, rr, rw, rd, mr, mw, m2r, asb, aop, br, bne, err, st};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the current cycle, then move to 1 ns after the next rising edge.
  task automatic cyc(input string tag, input logic [17:0] e);
    #1;
    check_eq(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  logic [17:0] e_zero, e_f_rdy, e_f_wait, e_dec, e_dec_nop, e_ex_r, e_ex_ls, e_ex_i;
  logic [17:0] e_mem_ld, e_mem_st, e_wb_r, e_wb_ld, e_wb_i, e_br_ne, e_br_eq;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    e_zero    = '0;
    e_f_rdy   = ev(1,1,0,0,0,1,0,0,2'b01,2'b00,0,0,0,3'd1);
    e_f_wait  = ev(0,0,0,0,0,1,0,0,2'b01,2'b00,0,0,0,3'd1);
    e_dec     = ev(0,0,1,0,0,0,0,0,2'b00,2'b00,0,0,0,3'd2);
    e_dec_nop = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,3'd2);
    e_ex_r    = ev(0,0,0,0,0,0,0,0,2'b00,2'b10,0,0,0,3'd3);
    e_ex_ls   = ev(0,0,0,0,0,0,0,0,2'b10,2'b00,0,0,0,3'd3);
    e_ex_i    = ev(0,0,0,0,0,0,0,0,2'b10,2'b11,0,0,0,3'd3);
    e_mem_ld  = ev(0,0,0,0,0,1,0,0,2'b00,2'b00,0,0,0,3'd4);
    e_mem_st  = ev(0,0,0,0,0,0,1,0,2'b00,2'b00,0,0,0,3'd4);
    e_wb_r    = ev(0,0,0,1,1,0,0,0,2'b00,2'b00,0,0,0,3'd5);
    e_wb_ld   = ev(0,0,0,1,0,0,0,1,2'b00,2'b00,0,0,0,3'd5);
    e_wb_i    = ev(0,0,0,1,0,0,0,0,2'b00,2'b00,0,0,0,3'd5);
    e_br_ne   = ev(0,0,0,0,0,0,0,0,2'b00,2'b01,0,1,0,3'd6);
    e_br_eq   = ev(0,0,0,0,0,0,0,0,2'b00,2'b01,1,0,0,3'd6);

    rst = 1'b1; opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
    #3;
    check_eq("reset_async", 32'(obs), 32'(e_zero));
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_held", 32'(obs), 32'(e_zero));
    rst = 1'b0;
    cyc("idle", e_zero);

    // R-type add: 1,2,3,5,1
    cyc("r_fetch", e_f_rdy);
    cyc("r_decode", e_dec);
    cyc("r_exec", e_ex_r);
    cyc("r_wb", e_wb_r);

    // lw with 3 wait cycles in MEM; opcode changed after DECODE must be ignored
    opcode = 6'b100011;
    cyc("lw_fetch", e_f_rdy);
    cyc("lw_decode", e_dec);
    opcode = 6'b000100; mem_ready = 1'b0;
    cyc("lw_exec", e_ex_ls);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", e_mem_ld);
    mem_ready = 1'b1;
    cyc("lw_mem_done", e_mem_ld);
    cyc("lw_wb", e_wb_ld);

    // sh: back to FETCH after 4 cycles, no writeback
    opcode = 6'b101001;
    cyc("sh_fetch", e_f_rdy);
    cyc("sh_decode", e_dec);
    cyc("sh_exec", e_ex_ls);
    cyc("sh_mem", e_mem_st);

    // bne / beq
    opcode = 6'b000101;
    cyc("bne_fetch", e_f_rdy);
    cyc("bne_decode", e_dec);
    cyc("bne_branch", e_br_ne);
    opcode = 6'b000100;
    cyc("beq_fetch", e_f_rdy);
    cyc("beq_decode", e_dec);
    cyc("beq_branch", e_br_eq);

    // jr: EXEC then straight to FETCH
    opcode = 6'b000000; funct = 6'b001000;
    cyc("jr_fetch", e_f_rdy);
    cyc("jr_decode", e_dec);
    cyc("jr_exec", e_ex_r);

    // addi (I-type ALU)
    opcode = 6'b001000; funct = 6'b000000;
    cyc("addi_fetch", e_f_rdy);
    cyc("addi_decode", e_dec);
    cyc("addi_exec", e_ex_i);
    cyc("addi_wb", e_wb_i);

    // FETCH holds without ir/pc write while memory is busy, then NOP
    opcode = 6'b010101; mem_ready = 1'b0;
    cyc("fetch_wait", e_f_wait);
    cyc("fetch_wait", e_f_wait);
    mem_ready = 1'b1;
    cyc("nop_fetch", e_f_rdy);
    cyc("nop_decode", e_dec_nop);

    // sw interrupted by reset in MEM
    opcode = 6'b101011;
    cyc("sw_fetch", e_f_rdy);
    cyc("sw_decode", e_dec);
    mem_ready = 1'b0;
    cyc("sw_exec", e_ex_ls);
    #1;
    check_eq("sw_mem", 32'(obs), 32'(e_mem_st));
    #1 rst = 1'b1;
    #1;
    check_eq("sw_reset_now", 32'(obs), 32'(e_zero));
    @(posedge clk);
    #1;
    check_eq("sw_reset_held", 32'(obs), 32'(e_zero));
    rst = 1'b0; mem_ready = 1'b1;
    cyc("idle2", e_zero);

    // Memory never ready in FETCH
    mem_ready = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) cyc("to_wait", e_f_wait);
    cyc("to_abort", ev(0,0,0,0,0,1,0,0,2'b01,2'b00,0,0,1,3'd1));
    mem_ready = 1'b1;
    cyc("to_refetch", ev(1,1,0,0,0,1,0,0,2'b01,2'b00,0,0,1,3'd1));
`else
    for (int i = 0; i < 20; i++) cyc("no_to_wait", e_f_wait);
    mem_ready = 1'b1;
    cyc("no_to_fetch", e_f_rdy);
`endif
    rst = 1'b1;
    #1;
    check_eq("final_reset", 32'(obs), 32'(e_zero));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
